cache_refill_arbiter: RTL and testbench

CACHE_REFILL_ARBITER -- requirements
Module: cache_refill_arbiter

---
 rtl/cache_refill_arbiter.sv | 154 +++++++++++++++
 tb/tb_cache_refill_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_arbiter.sv
// Purpose : arbitrates block refill / write-back requests from several caches
//           onto a single word-wide RAM port and assembles refill blocks.
// Latency : resp_valid BLOCK_SIZE+1 cycles after the accepting IDLE cycle when
//           ram_ready is tied high; each low ram_ready cycle adds one cycle.
// Backpr. : ram_ready low freezes the beat (all RAM outputs hold); requesters
//           hold req_valid until resp_valid, and mem_stall covers that window.
//
// Optional feature: define CACHE_ARB_ROUND_ROBIN_EN for round-robin
// arbitration. Otherwise the lowest-numbered requesting port wins.
//
// Ports:
//   clk, rst           sole clock, synchronous active-high reset
//   req_valid/write    per-port request and direction (1 = write-back)
//   req_addr           per-port word address, ADDR_WIDTH bits per port
//   req_wblock         per-port write-back block, BLOCK_WIDTH bits per port
//   resp_valid         one-cycle completion pulse to the granted port
//   resp_block         refill buffer (shows the last refill in every state)
//   ram_en/write/addr/wdata, ram_rdata, ram_ready   word-wide RAM port
//   mem_stall          some port is requesting and not being answered
//   status, counter    FSM state and current beat
module cache_refill_arbiter #(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_WIDTH   = 30,
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 3
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [NUM_PORTS-1:0]                              req_valid,
  input  logic [NUM_PORTS-1:0]                              req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]                   req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH*(1<<OFFSET_WIDTH)-1:0] req_wblock,
  output logic [NUM_PORTS-1:0]                              resp_valid,
  output logic [DATA_WIDTH*(1<<OFFSET_WIDTH)-1:0]           resp_block,
  output logic                                              ram_en,
  output logic                                              ram_write,
  output logic [ADDR_WIDTH-1:0]                             ram_addr,
  output logic [DATA_WIDTH-1:0]                             ram_wdata,
  input  logic [DATA_WIDTH-1:0]                             ram_rdata,
  input  logic                                              ram_ready,
  output logic                                              mem_stall,
  output logic [1:0]                                        status,
  output logic [OFFSET_WIDTH-1:0]                           counter
);

  localparam int BLOCK_SIZE  = 1 << OFFSET_WIDTH;
  localparam int BLOCK_WIDTH = DATA_WIDTH * BLOCK_SIZE;
  localparam int IDX_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER_RD = 2'd1,
    XFER_WR = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                   state;
  logic [OFFSET_WIDTH-1:0]  beat;
  logic [IDX_W-1:0]         winner;
  logic [ADDR_WIDTH-1:0]    base;
  logic [BLOCK_WIDTH-1:0]   wblock;
  logic [BLOCK_WIDTH-1:0]   buffer;
  logic [IDX_W-1:0]         pick;
  logic                     xfer;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]         rr_ptr;

  // Scan from the farthest candidate back to the pointer so the last hit,
  // which is the one kept, is the first requester at or after rr_ptr.
  always_comb begin
    int idx;
    idx  = 0;
    pick = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_PORTS;
      if (req_valid[idx]) pick = IDX_W'(idx);
    end
  end
`else
  // Descending scan: the lowest-numbered requester is assigned last.
  always_comb begin
    pick = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_valid[k]) pick = IDX_W'(k);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      beat   <= '0;
      winner <= '0;
      base   <= '0;
      wblock <= '0;
      buffer <= '0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      rr_ptr <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            winner <= pick;
            base   <= req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH] & ~OFF_MASK;
            wblock <= req_wblock[pick*BLOCK_WIDTH +: BLOCK_WIDTH];
            beat   <= '0;
            state  <= req_write[pick] ? XFER_WR : XFER_RD;
          end
        end
        XFER_RD, XFER_WR: begin
          if (ram_ready) begin
            if (state == XFER_RD) begin
              buffer[beat*DATA_WIDTH +: DATA_WIDTH] <= ram_rdata;
            end
            if (&beat) begin
              state <= DONE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
          rr_ptr <= (int'(winner) == NUM_PORTS - 1) ? '0 : winner + IDX_W'(1);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs below decode registered state only (plus mem_stall, which
  // must see req_valid combinationally).
  assign xfer      = (state == XFER_RD) || (state == XFER_WR);
  assign ram_en    = xfer;
  assign ram_write = (state == XFER_WR);
  assign ram_addr  = xfer ? (base | ADDR_WIDTH'(beat)) : '0;
  assign ram_wdata = (state == XFER_WR) ? wblock[beat*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_comb begin
    resp_valid = '0;
    if (state == DONE) resp_valid[winner] = 1'b1;
  end

  assign resp_block = buffer;
  assign mem_stall  = |(req_valid & ~resp_valid);
  assign status     = state;
  assign counter    = beat;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
module tb_cache_refill_arbiter;
  localparam int N  = 2;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int OW = 3;
  localparam int BS = 8;
  localparam int BW = DW * BS;
  localparam logic [AW-1:0] OMASK = AW'(BS - 1);

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*BW-1:0] req_wblock;
  logic [N-1:0]    resp_valid;
  logic [BW-1:0]   resp_block;
  logic            ram_en, ram_write, ram_ready, mem_stall;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata, ram_rdata;
  logic [1:0]      status;
  logic [OW-1:0]   counter;

  cache_refill_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                         .OFFSET_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wblock(req_wblock), .resp_valid(resp_valid),
    .resp_block(resp_block), .ram_en(ram_en), .ram_write(ram_write),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_ready(ram_ready), .mem_stall(mem_stall), .status(status),
    .counter(counter));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model: a queue of outstanding beat offsets, a pending
  // completion flag and the refill buffer as an array of words.
  int            m_q[$];
  bit            m_done;
  int            m_win;
  bit            m_wr;
  int            m_ptr;
  logic [AW-1:0] m_base;
  logic [DW-1:0] m_wb[BS];
  logic [DW-1:0] m_buf[BS];

  logic [AW-1:0] obs_addr[$];
  logic [DW-1:0] obs_wd[$];
  logic          obs_wr[$];
  logic [AW-1:0] obs_hold_addr[$];
  logic [OW-1:0] obs_hold_cnt[$];
  logic [N-1:0]  obs_rv;
  logic          stall_at_resp;
  int            stall_bad;
  bit            resp_seen[N];

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] exp_block();
    logic [BW-1:0] r;
    for (int k = 0; k < BS; k++) r[k*DW +: DW] = m_buf[k];
    return r;
  endfunction

  function automatic int pick_winner();
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
    for (int k = 0; k < N; k++) if (req_valid[k]) return k;
`endif
    return -1;
  endfunction

  task automatic compare();
    bit            xf;
    logic [N-1:0]  erv;
    xf  = (m_q.size() > 0);
    erv = m_done ? N'(1 << m_win) : '0;
    chk("status", status, m_done ? 2'd3 : (xf ? (m_wr ? 2'd2 : 2'd1) : 2'd0));
    chk("ram_en", ram_en, xf);
    chk("ram_write", ram_write, xf && m_wr);
    if (xf) begin
      chk("ram_addr", ram_addr, m_base + AW'(m_q[0]));
      chk("ram_wdata", ram_wdata, m_wr ? m_wb[m_q[0]] : '0);
      chk("counter", counter, m_q[0]);
    end
    chk("resp_valid", resp_valid, erv);
    chk("resp_block", resp_block, exp_block());
    chk("mem_stall", mem_stall, |(req_valid & ~erv));
  endtask

  task automatic model_step();
    int w;
    if (rst) begin
      m_q.delete();
      m_done = 0;
      m_ptr  = 0;
      m_win  = 0;
      foreach (m_buf[k]) m_buf[k] = '0;
    end else if (m_done) begin
      m_done = 0;
      m_ptr  = (m_win + 1) % N;
    end else if (m_q.size() > 0) begin
      if (ram_ready) begin
        if (!m_wr) m_buf[m_q[0]] = ram_rdata;
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1;
      end
    end else begin
      w = pick_winner();
      if (w >= 0) begin
        m_win  = w;
        m_wr   = req_write[w];
        m_base = req_addr[w*AW +: AW] & ~OMASK;
        for (int k = 0; k < BS; k++) begin
          m_wb[k] = req_wblock[w*BW + k*DW +: DW];
          m_q.push_back(k);
        end
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    compare();
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Runs until resp_valid (bounded), recording the RAM beats it observes.
  task automatic run_txn(input int lo_from, input int lo_to, input bit keep, output int lat);
    lat = -1;
    obs_addr.delete(); obs_wd.delete(); obs_wr.delete();
    obs_hold_addr.delete(); obs_hold_cnt.delete();
    obs_rv = '0; stall_bad = 0; stall_at_resp = 1'b1;
    for (int n = 0; n < 60; n++) begin
      ram_ready = (n >= lo_from && n < lo_to) ? 1'b0 : 1'b1;
      ram_rdata = (m_q.size() > 0) ? 32'hA0 + 32'(m_q[0]) : 32'h0;
      sample();
      if (ram_en && ram_ready) begin
        obs_addr.push_back(ram_addr); obs_wd.push_back(ram_wdata); obs_wr.push_back(ram_write);
      end
      if (ram_en && !ram_ready) begin
        obs_hold_addr.push_back(ram_addr); obs_hold_cnt.push_back(counter);
      end
      if (|resp_valid) begin
        lat = n; obs_rv = resp_valid; stall_at_resp = mem_stall;
        step();
        break;
      end
      if (!mem_stall) stall_bad++;
      step();
    end
    if (!keep) req_valid = '0;
    ram_ready = 1'b1;
  endtask

  logic [BW-1:0] blk_a0;
  int lat;

  initial begin
    rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wblock = '0;
    ram_ready = 1'b0; ram_rdata = '0;
    m_done = 0; m_win = 0; m_wr = 0; m_ptr = 0; m_base = '0;
    foreach (m_buf[k]) begin m_buf[k] = '0; m_wb[k] = '0; end
    foreach (resp_seen[i]) resp_seen[i] = 0;
    for (int k = 0; k < BS; k++) blk_a0[k*DW +: DW] = 32'hA0 + 32'(k);
    repeat (2) @(posedge clk);
    #1;
    model_step();

    // Reset state
    sample();
    chk("rst_status", status, 2'd0);
    chk("rst_counter", counter, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_block", resp_block, 0);
    step();
    rst = 1'b0;

    // Port-1 refill of 0x13
    req_valid = 2'b10; req_write = 2'b00; req_addr[AW +: AW] = 30'h13;
    run_txn(0, 0, 0, lat);
    chk("rd_latency", lat, 9);
    chk("rd_resp_port", obs_rv, 2'b10);
    chk("rd_beats", obs_addr.size(), 8);
    foreach (obs_addr[k]) chk("rd_addr", obs_addr[k], 30'h10 + 30'(k));
    chk("rd_block", resp_block, blk_a0);

    // Port-1 write-back
    req_valid = 2'b10; req_write = 2'b10;
    for (int k = 0; k < BS; k++) req_wblock[BW + k*DW +: DW] = 32'h100 + 32'(k);
    run_txn(0, 0, 0, lat);
    chk("wr_latency", lat, 9);
    chk("wr_resp_port", obs_rv, 2'b10);
    chk("wr_beats", obs_wd.size(), 8);
    foreach (obs_wd[k]) begin
      chk("wr_wdata", obs_wd[k], 32'h100 + 32'(k));
      chk("wr_write", obs_wr[k], 1'b1);
    end
    chk("wr_block_kept", resp_block, blk_a0);

    // Port-0 refill with ram_ready low for 3 cycles on beat 4
    req_valid = 2'b01; req_write = 2'b00; req_addr[0 +: AW] = 30'h2345;
    run_txn(5, 8, 0, lat);
    chk("stall_latency", lat, 12);
    chk("hold_cycles", obs_hold_addr.size(), 3);
    foreach (obs_hold_addr[k]) begin
      chk("hold_addr", obs_hold_addr[k], 30'h2344);
      chk("hold_counter", obs_hold_cnt[k], 4);
    end
    foreach (obs_addr[k]) chk("stall_addr", obs_addr[k], 30'h2340 + 30'(k));
    chk("mem_stall_before", stall_bad, 0);
    chk("mem_stall_at_resp", stall_at_resp, 1'b0);

    // Reset during beat 5, held request restarts at beat 0
    req_valid = 2'b01; req_addr[0 +: AW] = 30'h80;
    for (int n = 0; n < 6; n++) begin sample(); step(); end
    rst = 1'b1;
    sample();
    chk("beat5_counter", counter, 5);
    step();
    rst = 1'b0;
    sample();
    chk("postrst_status", status, 2'd0);
    chk("postrst_ram_en", ram_en, 1'b0);
    chk("postrst_resp", resp_valid, 2'b00);
    step();
    sample();
    chk("restart_counter", counter, 0);
    chk("restart_addr", ram_addr, 30'h80);
    step();
    run_txn(0, 0, 0, lat);
    chk("restart_latency", lat, 7);
    chk("restart_port", obs_rv, 2'b01);

    // Both ports requesting continuously from a fresh pointer
    rst = 1'b1; sample(); step(); rst = 1'b0;
    req_valid = 2'b11; req_write = 2'b00;
    for (int t = 0; t < 4; t++) begin
      run_txn(0, 0, t < 3, lat);
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      chk("rr_grant", obs_rv, (t % 2 == 0) ? 2'b01 : 2'b10);
`else
      chk("fixed_grant", obs_rv, 2'b01);
`endif
      chk("both_latency", lat, 9);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      ram_ready = ($urandom_range(0, 3) != 0);
      ram_rdata = $urandom;
      for (int i = 0; i < N; i++) begin
        if (resp_seen[i]) begin
          resp_seen[i] = 0;
          if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_write[i] = $urandom_range(0, 1) == 1;
          req_addr[i*AW +: AW] = AW'($urandom);
          for (int k = 0; k < BS; k++) req_wblock[i*BW + k*DW +: DW] = $urandom;
        end else if (req_valid[i] && $urandom_range(0, 7) == 0) begin
          req_addr[i*AW +: AW] = AW'($urandom);
        end
      end
      sample();
      if (m_done && !rst) resp_seen[m_win] = 1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
